// File: rtl/jump_ras_pkg.sv
// Shared opcode/funct encodings and register numbers for the ID-stage jump
// classifier and return-address stack.
package jump_ras_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] EXE_JAL    = 6'b000011;  // opcode
    localparam logic [5:0] EXE_JR     = 6'b001000;  // funct under OP_SPECIAL
    localparam logic [5:0] EXE_JALR   = 6'b001001;  // funct under OP_SPECIAL

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [4:0] REG_RA     = 5'd31;

endpackage

// File: rtl/jump_ras_class.sv
// Combinational jump decode: link-write control plus the RAS push/pop intent.
module jump_class
    import jump_ras_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [4:0] rs,
    input  logic [4:0] rd,
    output logic       jsave,
    output logic       save_in_rd,
    output logic       jump_to_rs_val,
    output logic       is_push,
    output logic       is_pop
);

    logic is_jal, is_jr, is_jalr;

    assign is_jal  = (op == EXE_JAL);
    assign is_jr   = (op == OP_SPECIAL) && (funct == EXE_JR);
    assign is_jalr = (op == OP_SPECIAL) && (funct == EXE_JALR);

    assign jsave          = is_jal | is_jalr;
    assign save_in_rd     = is_jalr;
    assign jump_to_rs_val = is_jr | is_jalr;

    // JALR with rd = 0 discards the link, so it is not a call.
    assign is_push = is_jal | (is_jalr && (rd != REG_ZERO));
    assign is_pop  = (is_jr | is_jalr) && (rs == REG_RA);

endmodule

// File: rtl/jump_ras.sv
// ID-stage jump classifier with a circular return-address stack; exports the
// pre-update sp/cnt so EX can roll the stack back on a flush.
module jump_ras
    import jump_ras_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int AW    = 32,
    localparam int SPW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           id_valid,
    input  logic [5:0]     id_op,
    input  logic [5:0]     id_funct,
    input  logic [4:0]     id_rs,
    input  logic [4:0]     id_rd,
    input  logic [AW-1:0]  id_pc,
    input  logic           recover,
    input  logic [SPW-1:0] recover_sp,
    input  logic [SPW:0]   recover_cnt,
    output logic           jsave,
    output logic           save_in_rd,
    output logic           jump_to_rs_val,
    output logic [AW-1:0]  link_addr,
    output logic           pred_valid,
    output logic [AW-1:0]  pred_target,
    output logic [SPW-1:0] snap_sp,
    output logic [SPW:0]   snap_cnt
);

    logic           is_push, is_pop;
    logic [AW-1:0]  mem_q [DEPTH];
    logic [SPW-1:0] sp_q, sp_d, top_idx, wr_idx;
    logic [SPW:0]   cnt_q, cnt_d;
    logic           wr_en, has_entry;

    jump_class u_class (
        .op             (id_op),
        .funct          (id_funct),
        .rs             (id_rs),
        .rd             (id_rd),
        .jsave          (jsave),
        .save_in_rd     (save_in_rd),
        .jump_to_rs_val (jump_to_rs_val),
        .is_push        (is_push),
        .is_pop         (is_pop)
    );

    assign link_addr   = id_pc + AW'(8);
    assign has_entry   = (cnt_q != '0);
    assign top_idx     = sp_q - SPW'(1);
    assign pred_valid  = is_pop & has_entry;
    assign pred_target = pred_valid ? mem_q[top_idx] : '0;
    assign snap_sp     = sp_q;
    assign snap_cnt    = cnt_q;

    always_comb begin
        sp_d   = sp_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = sp_q;
        if (recover) begin
            sp_d  = recover_sp;
            cnt_d = recover_cnt;
        end else if (id_valid) begin
            // Call-and-return in one instruction replaces the top in place;
            // on an empty stack there is nothing to replace, so it pushes.
            if (is_push && is_pop && has_entry) begin
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end else if (is_push) begin
                wr_en = 1'b1;
                sp_d  = sp_q + SPW'(1);
                if (cnt_q != (SPW+1)'(DEPTH))
                    cnt_d = cnt_q + (SPW+1)'(1);
            end else if (is_pop && has_entry) begin
                sp_d  = sp_q - SPW'(1);
                cnt_d = cnt_q - (SPW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            if (wr_en)
                mem_q[wr_idx] <= link_addr;
        end
    end

endmodule

// File: tb/tb_jump_ras.sv
// Bench for jump_ras: directed scenarios plus random traffic, scored against a
// behavioural stack model through an expected-response queue.
module tb_jump_ras;

    localparam int DEPTH = 8;
    localparam int AW    = 32;
    localparam int SPW   = 3;

    logic           clk = 1'b0;
    logic           resetn;
    logic           id_valid;
    logic [5:0]     id_op, id_funct;
    logic [4:0]     id_rs, id_rd;
    logic [AW-1:0]  id_pc;
    logic           recover;
    logic [SPW-1:0] recover_sp;
    logic [SPW:0]   recover_cnt;
    logic           jsave, save_in_rd, jump_to_rs_val, pred_valid;
    logic [AW-1:0]  link_addr, pred_target;
    logic [SPW-1:0] snap_sp;
    logic [SPW:0]   snap_cnt;

    jump_ras #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_op(id_op),
        .id_funct(id_funct), .id_rs(id_rs), .id_rd(id_rd), .id_pc(id_pc),
        .recover(recover), .recover_sp(recover_sp), .recover_cnt(recover_cnt),
        .jsave(jsave), .save_in_rd(save_in_rd), .jump_to_rs_val(jump_to_rs_val),
        .link_addr(link_addr), .pred_valid(pred_valid), .pred_target(pred_target),
        .snap_sp(snap_sp), .snap_cnt(snap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        jsave, save_in_rd, jrs, pv;
        logic [31:0] link, pt;
        int          ssp, scnt;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference stack: a ring of return addresses with a free-slot index and depth.
    logic [31:0] m_mem [DEPTH];
    int          m_sp, m_cnt;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("jsave",       32'(jsave),          32'(e.jsave));
            chk("save_in_rd",  32'(save_in_rd),     32'(e.save_in_rd));
            chk("jump_to_rs",  32'(jump_to_rs_val), 32'(e.jrs));
            chk("link_addr",   link_addr,           e.link);
            chk("pred_valid",  32'(pred_valid),     32'(e.pv));
            chk("pred_target", pred_target,         e.pt);
            chk("snap_sp",     32'(snap_sp),        32'(e.ssp));
            chk("snap_cnt",    32'(snap_cnt),       32'(e.scnt));
        end
    end

    function automatic void model_reset();
        m_sp  = 0;
        m_cnt = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one ID cycle, predict its outputs from the model, then advance the model.
    task automatic issue(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rd, input logic [31:0] pc,
                         input logic rec, input int rsp, input int rcnt);
        exp_t e;
        logic jal, jr, jalr, push, pop;
        int   top;
        id_valid = v; id_op = op; id_funct = fn; id_rs = rs; id_rd = rd; id_pc = pc;
        recover = rec; recover_sp = 3'(rsp); recover_cnt = 4'(rcnt);
        jal  = (op == 6'd3);
        jr   = (op == 6'd0) && (fn == 6'd8);
        jalr = (op == 6'd0) && (fn == 6'd9);
        push = jal || (jalr && rd != 5'd0);
        pop  = (jr || jalr) && rs == 5'd31;
        top  = (m_sp + DEPTH - 1) % DEPTH;
        e.jsave = jal || jalr;
        e.save_in_rd = jalr;
        e.jrs  = jr || jalr;
        e.link = pc + 32'd8;
        e.pv   = pop && m_cnt > 0;
        e.pt   = e.pv ? m_mem[top] : 32'd0;
        e.ssp  = m_sp;
        e.scnt = m_cnt;
        exp_q.push_back(e);
        if (rec) begin
            m_sp  = rsp;
            m_cnt = rcnt;
        end else if (v) begin
            if (push && pop && m_cnt > 0) begin
                m_mem[top] = e.link;
            end else if (push) begin
                m_mem[m_sp] = e.link;
                m_sp = (m_sp + 1) % DEPTH;
                if (m_cnt < DEPTH) m_cnt++;
            end else if (pop && m_cnt > 0) begin
                m_sp = top;
                m_cnt--;
            end
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        id_valid = 1'b1; id_op = 6'd3; id_pc = 32'h0;
        recover = 1'b1;
        tick();
        resetn = 1'b1;
        recover = 1'b0;
        model_reset();
    endtask

    task automatic jal(input logic [31:0] pc);
        issue(1'b1, 6'd3, 6'd0, 5'd0, 5'd0, pc, 1'b0, 0, 0);
    endtask

    task automatic jr(input logic [4:0] rs, input logic [31:0] pc);
        issue(1'b1, 6'd0, 6'd8, rs, 5'd0, pc, 1'b0, 0, 0);
    endtask

    task automatic jalr(input logic [4:0] rd, input logic [4:0] rs, input logic [31:0] pc);
        issue(1'b1, 6'd0, 6'd9, rs, rd, pc, 1'b0, 0, 0);
    endtask

    initial begin
        int snap_s, snap_c, budget;
        resetn = 1'b0; id_valid = 1'b0; id_op = '0; id_funct = '0; id_rs = '0;
        id_rd = '0; id_pc = '0; recover = 1'b0; recover_sp = '0; recover_cnt = '0;
        model_reset();
        tick();
        do_reset();

        // Empty stack: JR $ra cannot predict.
        jr(5'd31, 32'h100); #1;
        chk("empty_pv", 32'(pred_valid), 32'd0);
        chk("empty_pt", pred_target, 32'd0);
        tick();
        jr(5'd31, 32'h104); #1;
        chk("empty_cnt", 32'(snap_cnt), 32'd0);
        tick();

        // Call then return.
        jal(32'h400); tick();
        jr(5'd31, 32'h500); #1;
        chk("ret_pv", 32'(pred_valid), 32'd1);
        chk("ret_pt", pred_target, 32'h408);
        tick();
        jr(5'd31, 32'h504); #1;
        chk("ret_empty_pv", 32'(pred_valid), 32'd0);
        tick();

        // Overflow: nine calls into an eight-entry stack.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            jal(32'h1000 + 32'(i) * 32'h10); tick();
        end
        for (int k = 0; k < 9; k++) begin
            jr(5'd31, 32'h2000); #1;
            if (k == 0) chk("ovf_cnt", 32'(snap_cnt), 32'd8);
            if (k < 8) chk("ovf_pt", pred_target, 32'h1088 - 32'(k) * 32'h10);
            else       chk("ovf_pv_last", 32'(pred_valid), 32'd0);
            tick();
        end

        // JALR $ra,$ra replaces the top.
        do_reset();
        jal(32'h200); tick();
        jalr(5'd31, 5'd31, 32'h300); #1;
        chk("repl_pt", pred_target, 32'h208);
        chk("repl_rd", 32'(save_in_rd), 32'd1);
        tick();
        jr(5'd31, 32'h320); #1;
        chk("repl_pt2", pred_target, 32'h308);
        chk("repl_cnt", 32'(snap_cnt), 32'd1);
        tick();

        // Recover drops the concurrent JAL and rewinds sp/cnt.
        do_reset();
        jal(32'h500); tick();
        snap_s = m_sp; snap_c = m_cnt;
        jal(32'h600); tick();
        jal(32'h700); tick();
        issue(1'b1, 6'd3, 6'd0, 5'd0, 5'd0, 32'h800, 1'b1, snap_s, snap_c); tick();
        jr(5'd31, 32'h900); #1;
        chk("rec_cnt", 32'(snap_cnt), 32'd1);
        chk("rec_pt", pred_target, 32'h508);
        tick();

        // Indirect jumps not through $ra leave the stack alone.
        jal(32'hA00); tick();
        jr(5'd5, 32'hB00); #1;
        chk("jr5_rs", 32'(jump_to_rs_val), 32'd1);
        chk("jr5_pv", 32'(pred_valid), 32'd0);
        tick();
        jalr(5'd0, 5'd4, 32'hB04); #1;
        chk("jalr0_rs", 32'(jump_to_rs_val), 32'd1);
        chk("jalr0_pv", 32'(pred_valid), 32'd0);
        tick();
        jr(5'd31, 32'hB08); #1;
        chk("jr5_keep", pred_target, 32'hA08);
        tick();

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            logic [5:0] op, fn;
            logic [4:0] rs, rd;
            logic [31:0] pc;
            int kind;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                continue;
            end
            pc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
            rs = 5'($urandom); rd = 5'($urandom); fn = 6'($urandom); op = 6'd0;
            kind = $urandom_range(0, 5);
            case (kind)
                0: op = 6'd3;
                1: begin fn = 6'd8; rs = 5'd31; end
                2: fn = 6'd8;
                3: begin
                    fn = 6'd9;
                    if ($urandom_range(0, 1) == 1) rs = 5'd31;
                    case ($urandom_range(0, 2))
                        0: rd = 5'd0;
                        1: rd = 5'd31;
                        default: ;
                    endcase
                end
                4: op = 6'($urandom);
                default: op = 6'h23;
            endcase
            issue($urandom_range(0, 9) != 0, op, fn, rs, rd, pc,
                  $urandom_range(0, 19) == 0, $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, DEPTH));
            tick();
        end

        id_valid = 1'b0; recover = 1'b0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            tick();
            budget++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
